capture_unit: RTL and testbench

Input-capture block: a free-running timer plus an edge detector that timestamps transitions on an external pin and queues the timestamps in a small FIFO drained over a valid/ready handshake. It is the consumer of the count-and-compare timer family: where the counter generates match/overflow events from time, this block converts external events back into time values. Sits beside the counter on the same clock, feeding a CPU/bus reader.

---
 rtl/capture_pkg.sv | 28 ++
 rtl/capture_fifo.sv | 69 ++++++
 rtl/capture_unit.sv | 96 +++++++++
 tb/tb_capture_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the input-capture block: edge-select encodings,
// default sizing and the edge-match helper.
package capture_pkg;

  localparam int CAP_BIN_DEF   = 32;
  localparam int CAP_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  function automatic logic edge_match(input logic [1:0] sel, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (sel)
      EDGE_NONE: hit = 1'b0;
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Show-ahead timestamp FIFO. A push into a full FIFO is accepted only when a
// pop retires the head on the same edge; otherwise it is reported as dropped.
module capture_fifo #(
  parameter int bin   = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [bin-1:0]           i_data,
  input  logic                     i_pop,
  output logic [bin-1:0]           o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [bin-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = i_pop & ~w_empty;
  // A pop on the same edge frees the slot the full-FIFO push needs.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_level = r_level;
  assign o_drop  = i_push & w_full & ~w_pop & ~i_clear;

endmodule

// File: rtl/capture_unit.sv
// Input capture: free-running timer, 3-flop synchronizer with edge detect,
// and a timestamp FIFO drained over valid/ready. Sticky lost flag on drops.
module capture_unit
  import capture_pkg::*;
#(
  parameter int bin   = CAP_BIN_DEF,
  parameter int DEPTH = CAP_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [1:0]             edge_sel,
  input  logic                   cap_in,
  output logic [bin-1:0]         oCapture,
  output logic                   cap_valid,
  input  logic                   cap_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   lost
);

  logic [bin-1:0] r_timer;
  logic           r_ovf;
  logic           r_lost;
  logic           r_s1;
  logic           r_s2;
  logic           r_s3;

  logic w_rise;
  logic w_fall;
  logic w_req;
  logic w_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_timer <= '0;
      r_ovf   <= 1'b0;
    end else if (enable) begin
      r_timer <= r_timer + 1'b1;
      r_ovf   <= &r_timer;
    end else begin
      r_ovf   <= 1'b0;
    end
  end

  // Synchronizer keeps running while disabled so re-enabling never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= cap_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_req  = enable & ~clear & edge_match(edge_sel, w_rise, w_fall);

  capture_fifo #(
    .bin   (bin),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (clear),
    .i_push  (w_req),
    .i_data  (r_timer),
    .i_pop   (cap_ready),
    .o_data  (oCapture),
    .o_valid (cap_valid),
    .o_level (level),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lost <= 1'b0;
    end else if (clear) begin
      r_lost <= 1'b0;
    end else if (w_drop) begin
      r_lost <= 1'b1;
    end
  end

  assign ovf  = r_ovf;
  assign lost = r_lost;

endmodule

// File: tb/tb_capture_unit.sv
// Directed bench for capture_unit (bin=8, DEPTH=4): latency, edges, drops,
// wrap, clear, disable and asynchronous reset.
module tb_capture_unit;
  import capture_pkg::*;

  localparam int BW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic [1:0]    edge_sel;
  logic          cap_in;
  logic [BW-1:0] oCapture;
  logic          cap_valid;
  logic          cap_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          lost;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] tm;
  logic [7:0] exp_q [5];
  logic [7:0] seen [2];
  logic [7:0] s0;
  int         n_seen;
  int         ovf_pos [$];

  always #5 clk = ~clk;

  capture_unit #(.bin(BW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .clear     (clear),
    .edge_sel  (edge_sel),
    .cap_in    (cap_in),
    .oCapture  (oCapture),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .level     (level),
    .ovf       (ovf),
    .lost      (lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // tm tracks the timer value the DUT holds during the current cycle.
  task automatic tick();
    @(posedge clk);
    if (clear) tm = 8'd0;
    else if (enable) tm = tm + 8'd1;
    #1;
  endtask

  task automatic toggle_and_settle(output logic [7:0] stamp);
    stamp = tm + 8'd2;
    cap_in = ~cap_in;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; edge_sel = 2'b01;
    cap_in = 1'b0; cap_ready = 1'b0; tm = 8'd0;
    #2;
    check("rst_ocap", oCapture, 0);
    check("rst_valid", cap_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_lost", lost, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; tm = 8'd0;

    // latency: cap_in rises while timer = 10
    repeat (10) tick();
    cap_in = 1'b1;
    tick(); check("lat_n", cap_valid, 0);
    tick(); check("lat_n1", cap_valid, 0);
    tick(); check("lat_valid", cap_valid, 1);
    check("lat_stamp", oCapture, 12);
    check("lat_level", level, 1);
    cap_ready = 1'b1; tick(); cap_ready = 1'b0;
    check("pop_level", level, 0);
    check("pop_valid", cap_valid, 0);

    // falling edge ignored in rise-only mode
    cap_in = 1'b0; repeat (3) tick();
    check("rise_only_level", level, 0);

    // both edges, 5-cycle pulse, continuous drain
    edge_sel = 2'b11; cap_ready = 1'b1; n_seen = 0;
    s0 = tm + 8'd2; cap_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) cap_in = 1'b0;
      tick();
      if (cap_valid) begin
        if (n_seen < 2) seen[n_seen] = oCapture;
        n_seen++;
      end
    end
    cap_ready = 1'b0;
    check("both_count", n_seen, 2);
    check("both_first", seen[0], s0);
    check("both_second", seen[1], s0 + 8'd5);
    check("both_diff", seen[1] - seen[0], 5);
    check("both_level", level, 0);

    // fill, then drop a fifth capture
    for (int i = 0; i < 4; i++) toggle_and_settle(exp_q[i]);
    check("fill_level", level, 4);
    check("fill_lost", lost, 0);
    toggle_and_settle(exp_q[4]);
    check("drop_level", level, 4);
    check("drop_lost", lost, 1);
    cap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drop_head%0d", i), oCapture, exp_q[i]);
      tick();
    end
    cap_ready = 1'b0;
    check("drop_drained", level, 0);
    check("lost_sticky", lost, 1);

    // clear with entries queued and lost set
    toggle_and_settle(exp_q[0]);
    toggle_and_settle(exp_q[1]);
    check("preclr_level", level, 2);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_level", level, 0);
    check("clr_lost", lost, 0);
    check("clr_valid", cap_valid, 0);
    toggle_and_settle(exp_q[0]);
    check("clr_timer_zero", oCapture, 2);
    cap_ready = 1'b1; tick(); cap_ready = 1'b0;

    // full FIFO push with a pop on the same edge
    for (int i = 0; i < 4; i++) toggle_and_settle(exp_q[i]);
    check("refill_level", level, 4);
    exp_q[4] = tm + 8'd2;
    cap_in = ~cap_in;
    tick(); tick();
    cap_ready = 1'b1; tick(); cap_ready = 1'b0;
    check("pushpop_level", level, 4);
    check("pushpop_lost", lost, 0);
    cap_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("pushpop_head%0d", i), oCapture, exp_q[i]);
      tick();
    end
    cap_ready = 1'b0;
    check("pushpop_drained", level, 0);

    // timer wrap: ovf after edges 256 and 512 following clear
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 1; k <= 520; k++) begin
      tick();
      if (ovf) ovf_pos.push_back(k);
    end
    check("ovf_count", ovf_pos.size(), 2);
    check("ovf_first", ovf_pos[0], 256);
    check("ovf_second", ovf_pos[1], 512);

    // disabled: edges ignored
    enable = 1'b0;
    cap_in = ~cap_in; repeat (3) tick();
    cap_in = ~cap_in; repeat (3) tick();
    check("dis_level", level, 0);
    check("dis_valid", cap_valid, 0);
    enable = 1'b1; repeat (3) tick();
    check("reen_level", level, 0);

    // asynchronous reset mid-drain
    for (int i = 0; i < 5; i++) toggle_and_settle(exp_q[i]);
    check("prerst_lost", lost, 1);
    cap_ready = 1'b1; tick();
    check("prerst_level", level, 3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", cap_valid, 0);
    check("arst_level", level, 0);
    check("arst_ocap", oCapture, 0);
    check("arst_lost", lost, 0);
    check("arst_ovf", ovf, 0);
    cap_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
